// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder. A single 4-bit ripple slice is reused once
//   per clock, walking from the least significant nibble upward. A registered
//   carry links one nibble to the next. Operands are captured when start is
//   accepted, so the caller may change A/B/c_in freely afterwards.
//
// Ports
//   Clk    in   1      rising-edge clock
//   Reset  in   1      synchronous active-high reset, overrides everything
//   start  in   1      request; honoured only in IDLE or DONE
//   A, B   in   WIDTH  addends, captured with an accepted start
//   c_in   in   1      carry into nibble 0, captured with an accepted start
//   busy   out  1      high while nibbles are being computed
//   done   out  1      one-cycle pulse marking Sum/c_out/ovf valid
//   Sum    out  WIDTH  A+B+c_in mod 2^WIDTH, held until the next accepted start
//   c_out  out  1      carry out of bit WIDTH-1
//   ovf    out  1      two's-complement overflow of the addition
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = $clog2(NIB);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // 4-bit ripple slice: returns {carry_out, sum[3:0]}
  function automatic logic [4:0] slice_add(input logic [3:0] a_nib,
                                           input logic [3:0] b_nib,
                                           input logic       cin);
    return {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cin};
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;

  logic [3:0]         nib_a_s;
  logic [3:0]         nib_b_s;
  logic [4:0]         slice_s;
  logic [WIDTH-1:0]   sum_merged_s;
  logic               last_s;

  // Select the active nibble of each operand and merge the slice result into Sum
  always_comb begin
    nib_a_s      = 4'h0;
    nib_b_s      = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        nib_a_s = a_q[4*i +: 4];
        nib_b_s = b_q[4*i +: 4];
      end else begin
        nib_a_s = nib_a_s;
        nib_b_s = nib_b_s;
      end
    end
    slice_s      = slice_add(nib_a_s, nib_b_s, carry_q);
    sum_merged_s = sum_q;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        sum_merged_s[4*i +: 4] = slice_s[3:0];
      end else begin
        sum_merged_s[4*i +: 4] = sum_q[4*i +: 4];
      end
    end
    last_s       = (cnt_q == CNT_W'(NIB - 1));
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer and its datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Accept new operands; Sum is cleared so partial bits never mix
          // with the previous result. c_out/ovf keep their old values.
          a_d     = A;
          b_d     = B;
          carry_d = c_in;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d   = sum_merged_s;
        carry_d = slice_s[4];
        if (last_s) begin
          cnt_d   = '0;
          c_out_d = slice_s[4];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (sum_merged_s[WIDTH-1] != a_q[WIDTH-1]);
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign Sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         Clk   = 1'b0;
  logic         Reset = 1'b1;
  logic         start = 1'b0;
  logic         c_in  = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic         busy, done, c_out, ovf;
  logic [W-1:0] Sum;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .A(A), .B(B), .c_in(c_in),
    .busy(busy), .done(done), .Sum(Sum), .c_out(c_out), .ovf(ovf)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: an accepted add at edge k is busy for cycles k..k+NIB-1,
  // done in cycle k+NIB, and its result is plain integer arithmetic.
  int           edge_k   = 0;
  int           acc_edge = 0;
  bit           have_op  = 0;
  bit           m_valid  = 0;
  bit           e_busy   = 0;
  bit           e_done   = 0;
  logic [W-1:0] m_sum    = '0;
  logic         m_cout   = 1'b0;
  logic         m_ovf    = 1'b0;
  logic [W-1:0] p_sum    = '0;
  logic         p_cout   = 1'b0;
  logic         p_ovf    = 1'b0;

  always @(posedge Clk) begin
    bit         prior_busy;
    logic [W:0] full;
    prior_busy = have_op && (edge_k - 1 - acc_edge) >= 0 && (edge_k - 1 - acc_edge) < NIB;
    if (Reset) begin
      have_op = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
      m_valid = 1;
    end else if (start && !prior_busy) begin
      full     = {1'b0, A} + {1'b0, B} + (W+1)'(c_in);
      p_sum    = full[W-1:0];
      p_cout   = full[W];
      p_ovf    = (A[W-1] == B[W-1]) && (full[W-1] != A[W-1]);
      acc_edge = edge_k;
      have_op  = 1;
      m_sum    = '0;
    end
    if (have_op && (edge_k - acc_edge) == NIB) begin
      m_sum  = p_sum;
      m_cout = p_cout;
      m_ovf  = p_ovf;
    end
    e_busy = have_op && (edge_k - acc_edge) >= 0 && (edge_k - acc_edge) < NIB;
    e_done = have_op && (edge_k - acc_edge) == NIB;
    edge_k++;
  end

  // Compare process: every cycle, away from the rising edge
  always @(negedge Clk) begin
    if (m_valid) begin
      chk("busy", {31'b0, busy}, {31'b0, e_busy});
      chk("done", {31'b0, done}, {31'b0, e_done});
      chk("c_out", {31'b0, c_out}, {31'b0, m_cout});
      chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
      if (!e_busy) chk("Sum", {16'b0, Sum}, {16'b0, m_sum});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One start pulse, then wait (bounded) for done and check literal results
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    bit got;
    A = a; B = b; c_in = ci; start = 1'b1;
    tick();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); c_in = 1'($urandom);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clk);
      if (done) got = 1;
    end
    chk({nm, "_done_seen"}, {31'b0, got}, 32'd1);
    if (got) begin
      chk({nm, "_sum"}, {16'b0, Sum}, {16'b0, es});
      chk({nm, "_cout"}, {31'b0, c_out}, {31'b0, ec});
      chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
    end
  endtask

  initial begin
    int dcount;
    int last_e;
    logic [W-1:0] seen_sum;

    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sum", {16'b0, Sum}, 32'd0);
    chk("rst_cout", {31'b0, c_out}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);

    // Latency: busy exactly NIB cycles, done in the following one
    A = 16'h1234; B = 16'h4321; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    dcount = 0;
    for (int i = 1; i <= NIB + 2; i++) begin
      @(negedge Clk);
      if (i <= NIB) chk("t1_busy", {31'b0, busy}, 32'd1);
      if (i == NIB + 1) begin
        chk("t1_done", {31'b0, done}, 32'd1);
        chk("t1_sum", {16'b0, Sum}, 32'h5555);
        chk("t1_cout", {31'b0, c_out}, 32'd0);
        chk("t1_ovf", {31'b0, ovf}, 32'd0);
      end
    end

    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    // start during RUN with other operands is ignored
    A = 16'h1111; B = 16'h2222; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    dcount = 0;
    seen_sum = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (done) begin dcount++; seen_sum = Sum; end
    end
    chk("t4_done_count", 32'(dcount), 32'd1);
    chk("t4_sum", {16'b0, seen_sum}, 32'h3333);

    run_op("t3a", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_op("t3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Reset on the second RUN cycle discards the add
    A = 16'h1357; B = 16'h2468; c_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_done", {31'b0, done}, 32'd0);
    chk("t5_sum", {16'b0, Sum}, 32'd0);
    chk("t5_cout", {31'b0, c_out}, 32'd0);
    run_op("t5b", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // start held high: back-to-back adds, done every NIB+1 cycles
    A = 16'h0001; B = 16'h0001; c_in = 1'b0; start = 1'b1;
    dcount = 0;
    last_e = -1;
    for (int i = 0; i < 32; i++) begin
      @(negedge Clk);
      if (done) begin
        chk("t6_sum", {16'b0, Sum}, 32'h0002);
        if (last_e >= 0) chk("t6_period", 32'(edge_k - last_e), 32'(NIB + 1));
        last_e = edge_k;
        dcount++;
      end
    end
    start = 1'b0;
    chk("t6_done_count_ge5", {31'b0, dcount >= 5}, 32'd1);
    tick(); tick(); tick(); tick(); tick(); tick();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 2) == 0);
      A     = W'($urandom);
      B     = W'($urandom);
      c_in  = 1'($urandom);
      Reset = ($urandom_range(0, 79) == 0);
      tick();
    end
    Reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
